// File: rtl/i2c_target_regfile.sv
// I2C target with a small register file: 7-bit address, register pointer byte,
// auto-incrementing burst reads/writes, repeated START, and a local parallel port.
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h1D,
    parameter int         NUM_REGS = 16,
    parameter int         PTR_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i2c_scl,
    inout  wire              i2c_sda,
    input  logic             i_loc_wr,
    input  logic [PTR_W-1:0] i_loc_addr,
    input  logic [7:0]       i_loc_wdata,
    output logic [7:0]       o_loc_rdata,
    output logic             o_bus_wr,
    output logic [PTR_W-1:0] o_bus_waddr,
    output logic [7:0]       o_bus_wdata,
    output logic             o_busy,
    output logic [3:0]       o_state
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR     = 4'd1;
    localparam logic [3:0] S_ADDR_ACK = 4'd2;
    localparam logic [3:0] S_PTR      = 4'd3;
    localparam logic [3:0] S_PTR_ACK  = 4'd4;
    localparam logic [3:0] S_WR_DATA  = 4'd5;
    localparam logic [3:0] S_WR_ACK   = 4'd6;
    localparam logic [3:0] S_RD_DATA  = 4'd7;
    localparam logic [3:0] S_RD_ACK   = 4'd8;
    localparam logic [3:0] S_IGNORE   = 4'd9;

    logic [1:0]       scl_sync_q, sda_sync_q;
    logic             scl_prev_q, sda_prev_q;
    logic [3:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             rw_q, rw_d, mack_q, mack_d, oe_q, oe_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             bus_wr_q, bus_wr_d, busy_q, busy_d;
    logic [PTR_W-1:0] bus_waddr_q, bus_waddr_d;
    logic [7:0]       bus_wdata_q, bus_wdata_d;
    logic [7:0]       regs_q [NUM_REGS];

    logic sda_s, scl_s, rise_s, fall_s, start_s, stop_s;
    logic [7:0] rx_byte_s, rd_byte_s;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign rise_s    = scl_s & ~scl_prev_q;
    assign fall_s    = ~scl_s & scl_prev_q;
    assign start_s   = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_s    = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte_s = {shift_q[6:0], sda_s};
    assign rd_byte_s = regs_q[ptr_q];

    assign i2c_sda     = oe_q ? 1'b0 : 1'bz;
    assign o_loc_rdata = regs_q[i_loc_addr];
    assign o_bus_wr    = bus_wr_q;
    assign o_bus_waddr = bus_waddr_q;
    assign o_bus_wdata = bus_wdata_q;
    assign o_busy      = busy_q;
    assign o_state     = state_q;

    // Bus sequencing; in ACK states cnt_q flags that the 9th rise has been seen.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        oe_d        = oe_q;
        ptr_d       = ptr_q;
        bus_wr_d    = 1'b0;
        bus_waddr_d = bus_waddr_q;
        bus_wdata_d = bus_wdata_q;
        if (start_s) begin
            state_d = S_ADDR;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
        end else if (stop_s) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WR_DATA: begin
                    if (rise_s) begin
                        shift_d = rx_byte_s;
                        if (cnt_q == 3'd7) begin
                            cnt_d = 3'd0;
                            if (state_q == S_ADDR) begin
                                rw_d    = rx_byte_s[0];
                                state_d = (rx_byte_s[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
                            end else if (state_q == S_PTR) begin
                                ptr_d   = rx_byte_s[PTR_W-1:0];
                                state_d = S_PTR_ACK;
                            end else begin
                                bus_wr_d    = 1'b1;
                                bus_waddr_d = ptr_q;
                                bus_wdata_d = rx_byte_s;
                                ptr_d       = ptr_q + PTR_W'(1);
                                state_d     = S_WR_ACK;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK, S_RD_ACK: begin
                    if (rise_s) begin
                        cnt_d  = 3'd1;
                        mack_d = sda_s;
                    end else if (fall_s && cnt_q == 3'd0) begin
                        oe_d = (state_q != S_RD_ACK);
                    end else if (fall_s) begin
                        cnt_d = 3'd0;
                        oe_d  = 1'b0;
                        if ((state_q == S_ADDR_ACK && rw_q) || (state_q == S_RD_ACK && !mack_q)) begin
                            state_d = S_RD_DATA;
                            shift_d = rd_byte_s;
                            oe_d    = ~rd_byte_s[7];
                            ptr_d   = ptr_q + PTR_W'(1);
                        end else if (state_q == S_ADDR_ACK) begin
                            state_d = S_PTR;
                        end else if (state_q == S_RD_ACK) begin
                            state_d = S_IGNORE;
                        end else begin
                            state_d = S_WR_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_RD_DATA: begin
                    if (rise_s) begin
                        cnt_d   = (cnt_q == 3'd7) ? 3'd0 : cnt_q + 3'd1;
                        state_d = (cnt_q == 3'd7) ? S_RD_ACK : S_RD_DATA;
                    end else if (fall_s) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_IDLE, S_IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
        busy_d = (state_d >= S_ADDR_ACK) && (state_d <= S_RD_ACK);
    end

    // Synchronizers, edge history and FSM/output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync_q  <= 2'b11;
            sda_sync_q  <= 2'b11;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            mack_q      <= 1'b0;
            oe_q        <= 1'b0;
            ptr_q       <= '0;
            bus_wr_q    <= 1'b0;
            bus_waddr_q <= '0;
            bus_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            scl_sync_q  <= {scl_sync_q[0], i2c_scl};
            sda_sync_q  <= {sda_sync_q[0], i2c_sda};
            scl_prev_q  <= scl_s;
            sda_prev_q  <= sda_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            oe_q        <= oe_d;
            ptr_q       <= ptr_d;
            bus_wr_q    <= bus_wr_d;
            bus_waddr_q <= bus_waddr_d;
            bus_wdata_q <= bus_wdata_d;
            busy_q      <= busy_d;
        end
    end

    // Register file: a bus write beats a local write to the same register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus_wr_d && bus_waddr_d == PTR_W'(i)) begin
                    regs_q[i] <= bus_wdata_d;
                end else if (i_loc_wr && i_loc_addr == PTR_W'(i)) begin
                    regs_q[i] <= i_loc_wdata;
                end else begin
                    regs_q[i] <= regs_q[i];
                end
            end
        end
    end

endmodule
